// File: rtl/sa_cache_controller.sv
// -----------------------------------------------------------------------------
// sa_cache_controller
// Set-associative, write-back / write-allocate cache controller holding
// 16-byte lines (four 32-bit words) for a single CPU and a line-wide memory.
//
// Parameters
//   WAYS : associativity (1, 2 or 4)
//   SETS : sets per way (power of two, 16..1024)
//
// Ports
//   clk, rst_n        : clock (rising edge) and asynchronous active-low reset
//   cpu_req_valid_i   : CPU request strobe, sampled only in IDLE
//   cpu_req_rw_i      : 1 = write, 0 = read
//   cpu_req_addr_i    : word-aligned byte address
//   cpu_req_data_i    : write data
//   cpu_data_ready_o  : one-cycle completion pulse
//   cpu_data_o        : read word, or the written word echoed back
//   mem_ready_i       : memory completion pulse
//   mem_data_i        : refill line
//   mem_req_valid_o   : memory request, held high for the whole transfer
//   mem_req_rw_o      : 1 = write-back, 0 = refill
//   mem_req_addr_o    : line address (bits [3:0] zero)
//   mem_req_data_o    : line being written back
// -----------------------------------------------------------------------------
module sa_cache_controller #(
    parameter int WAYS = 2,
    parameter int SETS = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req_valid_i,
    input  logic          cpu_req_rw_i,
    input  logic [31:0]   cpu_req_addr_i,
    input  logic [31:0]   cpu_req_data_i,
    output logic          cpu_data_ready_o,
    output logic [31:0]   cpu_data_o,
    input  logic          mem_ready_i,
    input  logic [127:0]  mem_data_i,
    output logic          mem_req_valid_o,
    output logic          mem_req_rw_o,
    output logic [31:0]   mem_req_addr_o,
    output logic [127:0]  mem_req_data_o
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - 4 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE
    } state_t;

    state_t state_q, state_d;

    // Latched request
    logic              req_rw_q;
    logic [31:0]       req_addr_q;
    logic [31:0]       req_data_q;
    logic [WAY_W-1:0]  victim_q;

    // Cache storage: status bits are reset, tags and line data are not
    logic              valid_q [WAYS][SETS];
    logic              dirty_q [WAYS][SETS];
    logic [WAY_W-1:0]  ptr_q   [SETS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [127:0]      data_q  [WAYS][SETS];

    logic [IDX_W-1:0]  req_index;
    logic [TAG_W-1:0]  req_tag;
    logic [1:0]        req_word;

    assign req_index = req_addr_q[4 +: IDX_W];
    assign req_tag   = req_addr_q[31 -: TAG_W];
    assign req_word  = req_addr_q[3:2];

    // The two byte-offset bits of a word-aligned address carry no information
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr_q[1:0]};

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [127:0]      hit_line;
    logic [WAY_W-1:0]  victim_sel;
    logic              victim_valid;
    logic              victim_dirty;
    logic [WAY_W-1:0]  ptr_next;

    // Tag lookup and victim choice for the latched request. Scanning the ways
    // from the top down lets the lowest invalid way win; when every way is
    // valid the set's round-robin pointer picks the victim.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        victim_sel = ptr_q[req_index];
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_index] && (tag_q[w][req_index] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][req_index]) begin
                victim_sel = WAY_W'(w);
            end
        end
        hit_line     = data_q[hit_way][req_index];
        victim_valid = valid_q[victim_sel][req_index];
        victim_dirty = dirty_q[victim_sel][req_index];
        ptr_next     = (victim_q == WAY_W'(WAYS - 1)) ? '0 : victim_q + 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpu_req_valid_i) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    state_d = IDLE;
                end else if (victim_valid && victim_dirty) begin
                    state_d = WRITE_BACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            WRITE_BACK: begin
                if (mem_ready_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (mem_ready_i) begin
                    state_d = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory-side outputs depend only on state and latched values, so they
    // hold steady for the whole transfer and fall to zero outside it.
    always_comb begin
        mem_req_valid_o = 1'b0;
        mem_req_rw_o    = 1'b0;
        mem_req_addr_o  = '0;
        mem_req_data_o  = '0;
        case (state_q)
            WRITE_BACK: begin
                mem_req_valid_o = 1'b1;
                mem_req_rw_o    = 1'b1;
                mem_req_addr_o  = {tag_q[victim_q][req_index], req_index, 4'h0};
                mem_req_data_o  = data_q[victim_q][req_index];
            end
            ALLOCATE: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = {req_tag, req_index, 4'h0};
            end
            default: ;
        endcase
    end

    // Request latch, status bits, victim register and CPU response.
    // Reset clears every valid bit, so an interrupted refill leaves nothing
    // valid behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_rw_q         <= 1'b0;
            req_addr_q       <= '0;
            req_data_q       <= '0;
            victim_q         <= '0;
            cpu_data_ready_o <= 1'b0;
            cpu_data_o       <= '0;
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
            end
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                end
            end
        end else begin
            cpu_data_ready_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_req_valid_i) begin
                        req_rw_q   <= cpu_req_rw_i;
                        req_addr_q <= cpu_req_addr_i;
                        req_data_q <= cpu_req_data_i;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        cpu_data_ready_o <= 1'b1;
                        if (req_rw_q) begin
                            dirty_q[hit_way][req_index] <= 1'b1;
                            cpu_data_o                  <= req_data_q;
                        end else begin
                            cpu_data_o <= hit_line[{req_word, 5'b0} +: 32];
                        end
                    end else begin
                        victim_q <= victim_sel;
                    end
                end
                ALLOCATE: begin
                    if (mem_ready_i) begin
                        valid_q[victim_q][req_index] <= 1'b1;
                        dirty_q[victim_q][req_index] <= 1'b0;
                        ptr_q[req_index]             <= ptr_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and line storage, written on a write hit (single word merge) and
    // when a refill completes.
    always_ff @(posedge clk) begin
        if (state_q == COMPARE && hit && req_rw_q) begin
            data_q[hit_way][req_index][{req_word, 5'b0} +: 32] <= req_data_q;
        end
        if (state_q == ALLOCATE && mem_ready_i) begin
            data_q[victim_q][req_index] <= mem_data_i;
            tag_q[victim_q][req_index]  <= req_tag;
        end
    end

endmodule
